// File: rtl/ysyx_22040895_csr_file.sv
// ysyx_22040895_csr_file: machine-mode CSR register file for the privileged-instruction unit
// Ports: clk/rst (async active-high); commit_i gates all writes and minstret;
//   csr_raddr_i -> csrrdata_o/csr_illegal_o (combinational, no write bypass);
//   csr_we_i/csr_waddr_i/csrwdata_i generic write; trap_i/trap_mepc_i/trap_mcause_i ecall entry;
//   mret_i/mret_mstatus_i mret return; rdata_{mepc,mcause,mtvec,mstatus}_o direct views.
// Macro YSYX_22040895_CSR_COUNTER_EN adds mcycle (0xB00) and minstret (0xB02).
module ysyx_22040895_csr_file #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000A_0000_1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_i,
    input  logic [11:0]     csr_raddr_i,
    output logic [XLEN-1:0] csrrdata_o,
    output logic            csr_illegal_o,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_waddr_i,
    input  logic [XLEN-1:0] csrwdata_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_mepc_i,
    input  logic [XLEN-1:0] trap_mcause_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mret_mstatus_i,
    output logic [XLEN-1:0] rdata_mepc_o,
    output logic [XLEN-1:0] rdata_mcause_o,
    output logic [XLEN-1:0] rdata_mtvec_o,
    output logic [XLEN-1:0] rdata_mstatus_o
);
    localparam logic [XLEN-1:0] MS_WMASK = XLEN'(64'h88);
    localparam logic [XLEN-1:0] MS_MPP   = XLEN'(64'h1800);

    logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mscratch_q, mscratch_d;
    logic tr, mr, wr;

    // Only MIE/MPIE are writable; everything else is pinned to the reset image with MPP=M.
    function automatic logic [XLEN-1:0] ms_fix(input logic [XLEN-1:0] v);
        return (MSTATUS_RST & ~MS_WMASK) | (v & MS_WMASK) | MS_MPP;
    endfunction

    assign tr = commit_i & trap_i;
    assign mr = commit_i & mret_i & ~trap_i;
    assign wr = commit_i & csr_we_i;

    always_comb begin
        mstatus_d = mstatus_q;
        if (tr) begin
            mstatus_d[7] = mstatus_q[3];
            mstatus_d[3] = 1'b0;
        end else if (mr) begin
            mstatus_d = ms_fix(mret_mstatus_i);
        end else if (wr && csr_waddr_i == 12'h300) begin
            mstatus_d = ms_fix(csrwdata_i);
        end
        mepc_d     = tr ? {trap_mepc_i[XLEN-1:1], 1'b0}
                   : (wr && csr_waddr_i == 12'h341) ? {csrwdata_i[XLEN-1:1], 1'b0} : mepc_q;
        mcause_d   = tr ? trap_mcause_i
                   : (wr && csr_waddr_i == 12'h342) ? csrwdata_i : mcause_q;
        mtvec_d    = (wr && csr_waddr_i == 12'h305) ? {csrwdata_i[XLEN-1:2], 2'b00} : mtvec_q;
        mscratch_d = (wr && csr_waddr_i == 12'h340) ? csrwdata_i : mscratch_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
        end
    end

`ifdef YSYX_22040895_CSR_COUNTER_EN
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    // A generic write replaces that cycle's increment rather than adding to it.
    always_comb begin
        mcycle_d   = (wr && csr_waddr_i == 12'hB00) ? csrwdata_i : mcycle_q + 64'd1;
        minstret_d = (wr && csr_waddr_i == 12'hB02) ? csrwdata_i : minstret_q + {63'd0, commit_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    always_comb begin
        csr_illegal_o = 1'b0;
        case (csr_raddr_i)
            12'h300: csrrdata_o = mstatus_q;
            12'h305: csrrdata_o = mtvec_q;
            12'h340: csrrdata_o = mscratch_q;
            12'h341: csrrdata_o = mepc_q;
            12'h342: csrrdata_o = mcause_q;
            12'hF14: csrrdata_o = '0;
`ifdef YSYX_22040895_CSR_COUNTER_EN
            12'hB00: csrrdata_o = mcycle_q;
            12'hB02: csrrdata_o = minstret_q;
`endif
            default: begin
                csrrdata_o    = '0;
                csr_illegal_o = 1'b1;
            end
        endcase
    end

    assign rdata_mepc_o    = mepc_q;
    assign rdata_mcause_o  = mcause_q;
    assign rdata_mtvec_o   = mtvec_q;
    assign rdata_mstatus_o = mstatus_q;
endmodule

// File: tb/tb_ysyx_22040895_csr_file.sv
// tb_ysyx_22040895_csr_file: directed scoreboard bench for the machine-mode CSR file
module tb_ysyx_22040895_csr_file;
    logic        clk, rst, commit_i, csr_we_i, trap_i, mret_i, csr_illegal_o;
    logic [11:0] csr_raddr_i, csr_waddr_i;
    logic [63:0] csrrdata_o, csrwdata_i, trap_mepc_i, trap_mcause_i, mret_mstatus_i;
    logic [63:0] rdata_mepc_o, rdata_mcause_o, rdata_mtvec_o, rdata_mstatus_o;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    ysyx_22040895_csr_file dut (
        .clk(clk), .rst(rst), .commit_i(commit_i),
        .csr_raddr_i(csr_raddr_i), .csrrdata_o(csrrdata_o), .csr_illegal_o(csr_illegal_o),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csrwdata_i(csrwdata_i),
        .trap_i(trap_i), .trap_mepc_i(trap_mepc_i), .trap_mcause_i(trap_mcause_i),
        .mret_i(mret_i), .mret_mstatus_i(mret_mstatus_i),
        .rdata_mepc_o(rdata_mepc_o), .rdata_mcause_o(rdata_mcause_o),
        .rdata_mtvec_o(rdata_mtvec_o), .rdata_mstatus_o(rdata_mstatus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_i = 0; csr_we_i = 0; trap_i = 0; mret_i = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        commit_i = 1; csr_we_i = 1; csr_waddr_i = a; csrwdata_i = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [11:0] a);
        csr_raddr_i = a;
        #1;
        chk(csrrdata_o);
    endtask

    initial begin
        rst = 1; idle();
        csr_raddr_i = 0; csr_waddr_i = 0; csrwdata_i = 0;
        trap_mepc_i = 0; trap_mcause_i = 0; mret_mstatus_i = 0;
        step(); step();
        push("rst_mstatus", 64'hA_0000_1800); chk(rdata_mstatus_o);
        push("rst_mtvec", 0); chk(rdata_mtvec_o);
        rst = 0;
        repeat (10) step();
`ifdef YSYX_22040895_CSR_COUNTER_EN
        push("mcycle_10", 64'd10); rd(12'hB00);
`else
        push("b00_data", 0); rd(12'hB00);
        push("b00_illegal", 1); chk({63'd0, csr_illegal_o});
`endif
        push("mstatus_mie", 64'hA_0000_1808); wr(12'h300, 64'h8); rd(12'h300);
        trap_i = 1; commit_i = 1; trap_mepc_i = 64'h8000_0010; trap_mcause_i = 64'd11;
        step(); idle();
        push("trap_mepc", 64'h8000_0010); chk(rdata_mepc_o);
        push("trap_mcause", 64'd11); chk(rdata_mcause_o);
        push("trap_mstatus", 64'hA_0000_1880); chk(rdata_mstatus_o);
        mret_i = 1; commit_i = 1; mret_mstatus_i = 64'hA_0000_1808;
        step(); idle();
        push("mret_mstatus", 64'hA_0000_1808); chk(rdata_mstatus_o);
        commit_i = 1; csr_we_i = 1; csr_waddr_i = 12'h340; csrwdata_i = 64'h55;
        push("no_bypass", 0); rd(12'h340);
        step(); idle();
        push("mscratch_wr", 64'h55); rd(12'h340);
        push("mtvec_mask", 64'h8000_0100); wr(12'h305, 64'h8000_0103); chk(rdata_mtvec_o);
        push("mepc_mask", 64'h8000_0004); wr(12'h341, 64'h8000_0005); rd(12'h341);
        push("mstatus_mask", 64'hA_0000_1888); wr(12'h300, '1); rd(12'h300);
        trap_i = 1; mret_i = 1; csr_we_i = 1; commit_i = 1;
        trap_mepc_i = 64'h101; trap_mcause_i = 64'd11; mret_mstatus_i = 0;
        csr_waddr_i = 12'h342; csrwdata_i = 64'd5;
        step(); idle();
        push("coll_mcause", 64'd11); chk(rdata_mcause_o);
        push("coll_mepc", 64'h100); chk(rdata_mepc_o);
        push("coll_mstatus", 64'hA_0000_1880); chk(rdata_mstatus_o);
        trap_i = 1; csr_we_i = 1; commit_i = 1; trap_mcause_i = 64'd7;
        csr_waddr_i = 12'h340; csrwdata_i = 64'h1234;
        step(); idle();
        push("trap_mscratch", 64'h1234); rd(12'h340);
        push("trap2_mcause", 64'd7); chk(rdata_mcause_o);
        push("trap2_mstatus", 64'hA_0000_1800); chk(rdata_mstatus_o);
        csr_we_i = 1; trap_i = 1; trap_mcause_i = 64'd3; csr_waddr_i = 12'h305; csrwdata_i = 64'hFFF0;
        step(); idle();
        push("nocommit_mtvec", 64'h8000_0100); chk(rdata_mtvec_o);
        push("nocommit_mcause", 64'd7); chk(rdata_mcause_o);
        push("ill_data", 0); rd(12'h7C0);
        push("ill_flag", 1); chk({63'd0, csr_illegal_o});
        push("mhartid_ro", 0); wr(12'hF14, 64'd5); rd(12'hF14);
        push("mhartid_legal", 0); chk({63'd0, csr_illegal_o});
`ifdef YSYX_22040895_CSR_COUNTER_EN
        wr(12'hB00, '1);
        push("mcycle_ones", '1); rd(12'hB00);
        step();
        push("mcycle_wrap", 0); rd(12'hB00);
        wr(12'hB02, 0);
        push("minstret_wr", 0); rd(12'hB02);
        commit_i = 1; repeat (3) step();
        commit_i = 0; repeat (2) step();
        push("minstret_cnt", 64'd3); rd(12'hB02);
`endif
        rst = 1;
        #1;
        push("rst2_mstatus", 64'hA_0000_1800); chk(rdata_mstatus_o);
        push("rst2_mtvec", 0); chk(rdata_mtvec_o);
        push("rst2_mepc", 0); chk(rdata_mepc_o);
        push("rst2_mcause", 0); chk(rdata_mcause_o);
        push("rst2_rd305", 0); rd(12'h305);
        push("rst2_ill305", 0); chk({63'd0, csr_illegal_o});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22040895_csr_file.md
Name: ysyx_22040895_csr_file

Overview:
Machine-mode CSR register file. It sits directly downstream of the privileged-instruction unit and consumes that unit's csrrw/csrrs write data, ecall mepc/mcause updates and mret mstatus update. It supplies combinational CSR read data, including dedicated mepc/mcause/mtvec/mstatus read ports, back to that unit. All state updates occur at instruction commit, on the rising clock edge.

Parameters:
XLEN, 64, CSR data width.
MSTATUS_RST, 64'h0000_000A_0000_1800, mstatus reset value (SXL=UXL=2, MPP=3).

Ports:
clk  in  1  clock, all updates on rising edge
rst  in  1  asynchronous, active-high reset
commit_i  in  1  instruction commits this cycle; gates every write and minstret increment
csr_raddr_i  in  12  generic read address
csrrdata_o  out  XLEN  read data for csr_raddr_i; combinational
csr_illegal_o  out  1  csr_raddr_i is unimplemented; combinational
csr_we_i  in  1  generic CSR write enable
csr_waddr_i  in  12  generic write address
csrwdata_i  in  XLEN  generic write data
trap_i  in  1  ecall trap entry
trap_mepc_i  in  XLEN  mepc value for the trap
trap_mcause_i  in  XLEN  mcause value for the trap
mret_i  in  1  mret commit
mret_mstatus_i  in  XLEN  new mstatus for mret
rdata_mepc_o / rdata_mcause_o / rdata_mtvec_o / rdata_mstatus_o  out  XLEN each  direct register views

Behaviour:
- Reset (async, while rst=1):
  - mstatus=MSTATUS_RST.
  - mtvec, mepc, mcause, mscratch = 0.
  - Counters = 0.
  - All outputs reflect these values immediately.
- Implemented addresses:
  - 0x300 mstatus, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause.
  - 0xF14 mhartid: read-only, reads 0.
  - 0xB00/0xB02: see Optional Feature.
- Any other read address: csrrdata_o=0, csr_illegal_o=1.
- Reads are purely combinational with no write bypass. A read in the same cycle as a write returns the old value; the new value is visible the following cycle.
- No write or increment happens unless commit_i=1.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] is hardwired to 2'b11. All other bits hold MSTATUS_RST values.
  - mtvec: bits[1:0] are forced to 0 (direct mode only).
  - mepc: bit[0] is forced to 0.
  - mcause, mscratch: full width writable.
- Writes to read-only or unimplemented addresses are silently dropped.
- Trap (trap_i & commit_i):
  - mepc <= trap_mepc_i (bit0 cleared).
  - mcause <= trap_mcause_i.
  - mstatus.MPIE <= old MIE; mstatus.MIE <= 0.
- Mret (mret_i & commit_i): mstatus <= mret_mstatus_i through the mstatus write mask.
- Priority when events coincide in one cycle: trap > mret > generic write.
  - A lower-priority event is dropped entirely, except that a generic write to a register the higher-priority event does not touch still completes.
  - Example: trap + write to mscratch means both occur.
- Latency: one cycle from commit to visible register value.
- A reset asserted mid-cycle overrides any pending write.

Optional Feature:
Macro YSYX_22040895_CSR_COUNTER_EN.
- Defined:
  - 64-bit mcycle (0xB00) increments every cycle after reset.
  - 64-bit minstret (0xB02) increments when commit_i=1.
  - Both are readable and writable.
  - A generic write to a counter overrides that cycle's increment; the written value appears next cycle, with no +1.
  - Counters wrap from all-ones to 0.
- Undefined:
  - 0xB00/0xB02 are unimplemented: they read 0 with csr_illegal_o=1, and writes are dropped.
  - No counter flops are generated.

Test Plan:
1. Reset check: assert rst mid-run, sample without a clock edge -> rdata_mstatus_o=0xA00001800; mtvec/mepc/mcause=0; csr_raddr_i=0x305 gives csrrdata_o=0, csr_illegal_o=0.
2. Trap entry and return:
   - Write mstatus=0x8 (MIE=1), then trap_i with mepc=0x80000010 and mcause=11 -> next cycle mepc=0x80000010, mcause=11, mstatus=0xA00001880.
   - Then mret_i with mstatus=0xA00001808 -> mstatus=0xA00001808.
3. Masks:
   - Write mtvec=0x80000103 -> reads 0x80000100.
   - Write mepc=0x80000005 -> reads 0x80000004.
   - Write mstatus=0xFFFFFFFFFFFFFFFF -> reads 0xA00001888.
4. Collisions:
   - trap_i + mret_i + csr write to mcause=5 in one cycle -> mcause=trap value, mret ignored.
   - trap_i + write mscratch=0x1234 -> mscratch=0x1234.
5. Gating and illegal access:
   - csr_we_i=1 with commit_i=0 -> no change.
   - Read 0x7C0 -> csrrdata_o=0, csr_illegal_o=1.
   - Write 0xF14=5 -> still reads 0.
6. Counters (macro defined):
   - After reset release, 10 cycles -> mcycle=10.
   - Write mcycle=0xFFFFFFFFFFFFFFFF -> reads all-ones next cycle, then 0 the cycle after.
   - minstret counts only commit_i cycles.
   - Macro undefined: read 0xB00 -> 0 with illegal flag set.
